syn_cmd_seq: RTL and testbench
==============================

# syn_cmd_seq

Command sequencer for the synthesizable testbench. Fetches fixed-width commands from a command memory, decodes them, and presents `cs`/`curr_cmd` to the emulation-host bridge, which services memory load/dump. Also drives CSB register writes into the DUT, timed waits, and the end-of-test `dollar_finish` pulse.

## Interface
- `CMD_W`, default `` `MSEQ_CMD_SIZE ``: command width in bits.
- `DEPTH`, default 1024: command memory entries.
- `ADDR_W`, default 10: command memory address width; DEPTH ≤ 2^ADDR_W.
- `clk`  in  1  testbench clock.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; starts execution from entry 0.
- `cmd_rd_en`  out  1  command memory read strobe.
- `cmd_rd_addr`  out  ADDR_W  command memory address.
- `cmd_rd_data`  in  CMD_W  read data, valid exactly 1 cycle after `cmd_rd_en`.
- `cs`  out  8  current state code.
- `curr_cmd`  out  CMD_W  command being executed.
- `csb_req`  out  1  register write request.
- `csb_addr`  out  32  register address, `curr_cmd[71:40]`.
- `csb_wdat`  out  32  write data, `curr_cmd[103:72]`.
- `csb_ready`  in  1  write accepted when sampled high with `csb_req`.
- `dollar_finish`  out  1  one-cycle end-of-test pulse.
- `done`  out  1  sticky; high in DONE or ERR.
- `cmd_err`  out  1  sticky; high in ERR.

## Operation
- Opcode is `curr_cmd[7:0]`. Legal opcodes: 0x00 NOP, 0x10 WAIT, 0x20 MEM_LD, 0x28 MEM_DMP, 0x30 REG_WR, 0xFF FINISH.
- The state code on `cs` doubles as the state encoding:
  - IDLE 0x00, FETCH 0x01, DECODE 0x02, WAIT 0x10, MEM_LD 0x20, MEM_DMP 0x28, REG_WR 0x30, DONE 0xFF, ERR 0xEE.
- IDLE→FETCH on `start`. `start` is ignored in every other state.
- FETCH: assert `cmd_rd_en` with `cmd_rd_addr`=pc; go to DECODE.
- DECODE: latch `cmd_rd_data` into `curr_cmd`, then branch on the opcode:
  - NOP → FETCH, pc+1.
  - WAIT → load the 32-bit counter from `curr_cmd[39:8]`.
  - MEM_LD / MEM_DMP → the matching state.
  - REG_WR → REG_WR.
  - FINISH → DONE.
  - Any other opcode → ERR.
- MEM_LD / MEM_DMP: held for exactly one cycle, then FETCH with pc+1. The consumer acts on every cycle `cs` matches, so one cycle is mandatory.
- WAIT: decrement each cycle. Leave for FETCH (pc+1) in the cycle the counter reads 0. A count of 0 spends exactly one cycle in WAIT.
- REG_WR:
  - `csb_req`=1 with address and data stable until `csb_ready`=1.
  - Then deassert and go to FETCH with pc+1.
  - `csb_ready` high outside REG_WR is ignored.
- DONE / ERR:
  - `dollar_finish`=1 for the entry cycle only.
  - The state is terminal until reset.
  - ERR also sets `cmd_err`.
- pc wrap: advancing past entry DEPTH-1 without a FINISH goes to ERR instead of FETCH.

## Timing
- Reset values:
  - `cs`=0x00, `curr_cmd`=0, pc=0.
  - `cmd_rd_en`=0, `csb_req`=0.
  - `dollar_finish`=0, `done`=0, `cmd_err`=0.
- All outputs are registered. `cs` and `curr_cmd` change on the same edge.
- Command-to-command overhead is 2 cycles (FETCH, DECODE).
  - Example: MEM_LD→MEM_LD spacing is 3 cycles.
- `start`→first `cmd_rd_en` is 1 cycle.
- Reset assertion mid-operation immediately clears all state, including an outstanding `csb_req`. No partial command resumes.

## Configuration
- `SYN_TB_CSB_TIMEOUT_EN` defined: REG_WR counts cycles with `csb_req` high.
  - Entering cycle 1024 without `csb_ready` goes to ERR.
  - In that cycle `csb_req` drops and `dollar_finish` pulses.
- Undefined: REG_WR waits indefinitely, and no counter logic is compiled in.

## Test plan
- Program [MEM_LD, FINISH], pulse `start` → `cs`=0x20 for exactly 1 cycle at cycle 3 after `start`, then `cs`=0xFF, `dollar_finish` 1 cycle, `done`=1.
- WAIT count 5 then FINISH → WAIT occupies 6 cycles. With count 0 → 1 cycle.
- REG_WR addr 0x5000 data 0xA5, `csb_ready` delayed 7 cycles → `csb_req` held 8 cycles with address and data stable, then FETCH.
- Opcode 0x44 → `cs`=0xEE, `cmd_err`=1, single `dollar_finish` pulse. A later `start` is ignored.
- DEPTH=4 filled with NOPs → ERR after entry 3. Then `resetn` pulse mid-WAIT → all outputs at reset values, and re-`start` executes from entry 0.
- With `SYN_TB_CSB_TIMEOUT_EN`, `csb_ready` tied low → ERR entered 1024 cycles after `csb_req` rises. Without the macro, still in REG_WR at cycle 5000.

Source files
------------

// File: rtl/syn_cmd_seq.sv
// Command sequencer: fetches, decodes and executes commands from a command memory.
// Optional macro SYN_TB_CSB_TIMEOUT_EN adds a 1024-cycle timeout on CSB register writes.
`ifndef MSEQ_CMD_SIZE
`define MSEQ_CMD_SIZE 128
`endif

module syn_cmd_seq #(
    parameter int CMD_W  = `MSEQ_CMD_SIZE,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              cmd_rd_en,
    output logic [ADDR_W-1:0] cmd_rd_addr,
    input  logic [CMD_W-1:0]  cmd_rd_data,
    output logic [7:0]        cs,
    output logic [CMD_W-1:0]  curr_cmd,
    output logic              csb_req,
    output logic [31:0]       csb_addr,
    output logic [31:0]       csb_wdat,
    input  logic              csb_ready,
    output logic              dollar_finish,
    output logic              done,
    output logic              cmd_err
);

    typedef enum logic [7:0] {
        S_IDLE    = 8'h00,
        S_FETCH   = 8'h01,
        S_DECODE  = 8'h02,
        S_WAIT    = 8'h10,
        S_MEM_LD  = 8'h20,
        S_MEM_DMP = 8'h28,
        S_REG_WR  = 8'h30,
        S_DONE    = 8'hFF,
        S_ERR     = 8'hEE
    } state_t;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_WAIT    = 8'h10;
    localparam logic [7:0] OP_MEM_LD  = 8'h20;
    localparam logic [7:0] OP_MEM_DMP = 8'h28;
    localparam logic [7:0] OP_REG_WR  = 8'h30;
    localparam logic [7:0] OP_FINISH  = 8'hFF;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       wait_cnt;
    logic              advance;
    logic              last_entry;
    logic              terminal;
    logic              next_terminal;

`ifdef SYN_TB_CSB_TIMEOUT_EN
    logic [9:0]        csb_cnt;
`endif

    assign cs          = state;
    assign cmd_rd_addr = pc;
    assign csb_addr    = curr_cmd[71:40];
    assign csb_wdat    = curr_cmd[103:72];

    assign last_entry    = (pc == LAST_PC);
    assign terminal      = (state == S_DONE) || (state == S_ERR);
    assign next_terminal = (next_state == S_DONE) || (next_state == S_ERR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // advance = current command finished, move to pc+1 (or fault on wrap)
    always_comb begin
        next_state = state;
        advance    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (cmd_rd_data[7:0])
                    OP_NOP:     advance    = 1'b1;
                    OP_WAIT:    next_state = S_WAIT;
                    OP_MEM_LD:  next_state = S_MEM_LD;
                    OP_MEM_DMP: next_state = S_MEM_DMP;
                    OP_REG_WR:  next_state = S_REG_WR;
                    OP_FINISH:  next_state = S_DONE;
                    default:    next_state = S_ERR;
                endcase
            end
            S_WAIT: begin
                if (wait_cnt == '0) advance = 1'b1;
            end
            S_MEM_LD, S_MEM_DMP: begin
                advance = 1'b1;
            end
            S_REG_WR: begin
                if (csb_ready) advance = 1'b1;
`ifdef SYN_TB_CSB_TIMEOUT_EN
                else if (csb_cnt == 10'd1023) next_state = S_ERR;
`endif
            end
            S_DONE, S_ERR: begin
                next_state = state;
            end
            default: begin
                next_state = S_ERR;
            end
        endcase
        if (advance) next_state = last_entry ? S_ERR : S_FETCH;
    end

    // Outputs are registered from next_state so they line up with cs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc            <= '0;
            curr_cmd      <= '0;
            wait_cnt      <= '0;
            cmd_rd_en     <= 1'b0;
            csb_req       <= 1'b0;
            dollar_finish <= 1'b0;
            done          <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            cmd_rd_en     <= (next_state == S_FETCH);
            csb_req       <= (next_state == S_REG_WR);
            dollar_finish <= next_terminal && !terminal;
            done          <= next_terminal;
            cmd_err       <= (next_state == S_ERR);
            if (state == S_IDLE && start) begin
                pc <= '0;
            end else if (advance && !last_entry) begin
                pc <= pc + 1'b1;
            end
            if (state == S_DECODE) begin
                curr_cmd <= cmd_rd_data;
                wait_cnt <= cmd_rd_data[39:8];
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 32'd1;
            end
        end
    end

`ifdef SYN_TB_CSB_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb_cnt <= '0;
        end else if (state == S_REG_WR) begin
            csb_cnt <= csb_cnt + 10'd1;
        end else begin
            csb_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_syn_cmd_seq.sv
// Scoreboard bench for syn_cmd_seq: directed programs push expected events,
// a negedge monitor turns DUT activity into events and compares them in order.
module tb_syn_cmd_seq;

    localparam int CMD_W  = 128;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    localparam int K_ST  = 1;
    localparam int K_CSB = 2;
    localparam int K_DF  = 3;

    logic              clk;
    logic              resetn;
    logic              start;
    logic              cmd_rd_en;
    logic [ADDR_W-1:0] cmd_rd_addr;
    logic [CMD_W-1:0]  cmd_rd_data;
    logic [7:0]        cs;
    logic [CMD_W-1:0]  curr_cmd;
    logic              csb_req;
    logic [31:0]       csb_addr;
    logic [31:0]       csb_wdat;
    logic              csb_ready;
    logic              dollar_finish;
    logic              done;
    logic              cmd_err;

    syn_cmd_seq #(.CMD_W(CMD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .cmd_rd_en(cmd_rd_en), .cmd_rd_addr(cmd_rd_addr), .cmd_rd_data(cmd_rd_data),
        .cs(cs), .curr_cmd(curr_cmd),
        .csb_req(csb_req), .csb_addr(csb_addr), .csb_wdat(csb_wdat), .csb_ready(csb_ready),
        .dollar_finish(dollar_finish), .done(done), .cmd_err(cmd_err)
    );

    typedef struct {
        int          kind;
        logic [7:0]  cs;
        int          t;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  fl;
    } ev_t;

    ev_t             q[$];
    int              n_chk  = 0;
    int              n_pass = 0;
    int              cyc    = 0;
    int              s_cyc  = 0;
    bit              mon_en = 0;
    logic [CMD_W-1:0] mem [0:DEPTH-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Command memory with one-cycle read latency
    always @(posedge clk) if (cmd_rd_en) cmd_rd_data <= mem[int'(cmd_rd_addr) % DEPTH];

    function automatic logic [CMD_W-1:0] mk(logic [7:0] op, logic [31:0] cnt,
                                            logic [31:0] ad, logic [31:0] dt);
        logic [CMD_W-1:0] c;
        c = '0;
        c[7:0]    = op;
        c[39:8]   = cnt;
        c[71:40]  = ad;
        c[103:72] = dt;
        return c;
    endfunction

    function automatic logic [127:0] pack(ev_t e);
        logic [31:0] tv;
        logic [7:0]  kv;
        tv = e.t;
        kv = e.kind[7:0];
        return {11'd0, kv, e.cs, tv, e.a, e.d, e.fl};
    endfunction

    task automatic check(string nm, bit ok, logic [127:0] act, logic [127:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    endtask

    task automatic push(int kind, logic [7:0] c, int t, logic [31:0] a, logic [31:0] d, logic [4:0] fl);
        ev_t e;
        e.kind = kind; e.cs = c; e.t = t; e.a = a; e.d = d; e.fl = fl;
        q.push_back(e);
    endtask

    task automatic st(logic [7:0] c, int t, logic [31:0] a, logic [4:0] fl);
        push(K_ST, c, t, a, 32'd0, fl);
    endtask

    task automatic emit(ev_t g);
        ev_t e;
        if (q.size() == 0) begin
            check("unexpected_event", 1'b0, pack(g), 128'd0);
        end else begin
            e = q.pop_front();
            if (e.t == -1) g.t = -1;
            check(e.kind == K_ST ? "state_event" : (e.kind == K_CSB ? "csb_event" : "finish_event"),
                  pack(g) == pack(e), pack(g), pack(e));
        end
    endtask

    // Monitor: flags are {cmd_rd_en, csb_req, dollar_finish, done, cmd_err}
    initial begin
        logic [7:0]  prev_cs;
        logic        req_prev;
        logic [31:0] ca, cd;
        int          clen, dlen;
        bit          cst;
        ev_t         g;
        prev_cs = 8'h00; req_prev = 1'b0; ca = '0; cd = '0; clen = 0; dlen = 0; cst = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (csb_req) begin
                    if (!req_prev) begin
                        ca = csb_addr; cd = csb_wdat; clen = 0; cst = 1'b1;
                    end
                    clen++;
                    if (csb_addr != ca || csb_wdat != cd) cst = 1'b0;
                end else if (req_prev) begin
                    g.kind = K_CSB; g.cs = 8'h00; g.t = clen; g.a = ca; g.d = cd; g.fl = {4'b0, cst};
                    emit(g);
                end
                req_prev = csb_req;
                if (cs != prev_cs) begin
                    g.kind = K_ST; g.cs = cs; g.t = cyc - s_cyc; g.a = curr_cmd[31:0]; g.d = '0;
                    g.fl = {cmd_rd_en, csb_req, dollar_finish, done, cmd_err};
                    emit(g);
                end
                prev_cs = cs;
                if (dollar_finish) begin
                    dlen++;
                end else if (dlen != 0) begin
                    g.kind = K_DF; g.cs = 8'h00; g.t = dlen; g.a = '0; g.d = '0; g.fl = '0;
                    emit(g);
                    dlen = 0;
                end
            end
        end
    end

    task automatic drain(int budget, string nm);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(nm, q.size() == 0, 128'(q.size()), 128'd0);
        q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic reset_expect();
        st(8'h00, -1, 32'd0, 5'b00000);
        @(posedge clk); #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        drain(5, "reset_event");
    endtask

    task automatic run_ld_finish(string nm);
        mem[0] = mk(8'h20, 0, 0, 0);
        mem[1] = mk(8'hFF, 0, 0, 0);
        st(8'h01, 1, 32'h0,  5'b10000);
        st(8'h02, 2, 32'h0,  5'b00000);
        st(8'h20, 3, 32'h20, 5'b00000);
        st(8'h01, 4, 32'h20, 5'b10000);
        st(8'h02, 5, 32'h20, 5'b00000);
        st(8'hFF, 6, 32'hFF, 5'b00110);
        push(K_DF, 8'h00, 1, 0, 0, 5'b0);
        pulse_start();
        drain(40, nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; start = 1'b0; csb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        mon_en = 1'b1;
        check("reset_values",
              {cs, curr_cmd, cmd_rd_addr, cmd_rd_en, csb_req, dollar_finish, done, cmd_err} == '0,
              128'({cs, cmd_rd_addr, cmd_rd_en, csb_req, dollar_finish, done, cmd_err}), 128'd0);
        check("reset_curr_cmd", curr_cmd == '0, curr_cmd, 128'd0);

        // MEM_LD then FINISH
        run_ld_finish("ld_finish");
        reset_expect();

        // WAIT 5 then FINISH, then WAIT 0 then FINISH
        for (int w = 0; w < 2; w++) begin
            int n;
            n = (w == 0) ? 5 : 0;
            mem[0] = mk(8'h10, n, 0, 0);
            mem[1] = mk(8'hFF, 0, 0, 0);
            st(8'h01, 1, 32'h0, 5'b10000);
            st(8'h02, 2, 32'h0, 5'b00000);
            st(8'h10, 3, 32'h10 | (n << 8), 5'b00000);
            st(8'h01, 4 + n, 32'h10 | (n << 8), 5'b10000);
            st(8'h02, 5 + n, 32'h10 | (n << 8), 5'b00000);
            st(8'hFF, 6 + n, 32'hFF, 5'b00110);
            push(K_DF, 8'h00, 1, 0, 0, 5'b0);
            pulse_start();
            drain(40, w == 0 ? "wait5" : "wait0");
            reset_expect();
        end

        // REG_WR with csb_ready delayed 7 cycles; early ready in FETCH/DECODE must be ignored
        mem[0] = mk(8'h30, 0, 32'h5000, 32'hA5);
        mem[1] = mk(8'hFF, 0, 0, 0);
        st(8'h01, 1, 32'h0, 5'b10000);
        st(8'h02, 2, 32'h0, 5'b00000);
        st(8'h30, 3, 32'h30, 5'b01000);
        push(K_CSB, 8'h00, 8, 32'h5000, 32'hA5, 5'b00001);
        st(8'h01, 11, 32'h30, 5'b10000);
        st(8'h02, 12, 32'h30, 5'b00000);
        st(8'hFF, 13, 32'hFF, 5'b00110);
        push(K_DF, 8'h00, 1, 0, 0, 5'b0);
        pulse_start();
        csb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 csb_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 csb_ready = 1'b1;
        @(posedge clk);
        #1 csb_ready = 1'b0;
        drain(40, "reg_wr");
        reset_expect();

        // Illegal opcode, then a start that must be ignored
        mem[0] = mk(8'h44, 0, 0, 0);
        st(8'h01, 1, 32'h0, 5'b10000);
        st(8'h02, 2, 32'h0, 5'b00000);
        st(8'hEE, 3, 32'h44, 5'b00111);
        push(K_DF, 8'h00, 1, 0, 0, 5'b0);
        pulse_start();
        drain(40, "bad_opcode");
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        check("err_terminal", {cs, done, cmd_err, dollar_finish} == {8'hEE, 3'b110},
              128'({cs, done, cmd_err, dollar_finish}), 128'({8'hEE, 3'b110}));
        drain(1, "err_no_events");
        reset_expect();

        // All NOPs: runs past the last entry into ERR
        for (int i = 0; i < DEPTH; i++) mem[i] = mk(8'h00, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            st(8'h01, 2 * i + 1, 32'h0, 5'b10000);
            st(8'h02, 2 * i + 2, 32'h0, 5'b00000);
        end
        st(8'hEE, 2 * DEPTH + 1, 32'h0, 5'b00111);
        push(K_DF, 8'h00, 1, 0, 0, 5'b0);
        pulse_start();
        drain(60, "pc_wrap");
        reset_expect();

        // Reset in the middle of a WAIT at entry 1, then restart from entry 0
        mem[1] = mk(8'h10, 20, 0, 0);
        st(8'h01, 1, 32'h0, 5'b10000);
        st(8'h02, 2, 32'h0, 5'b00000);
        st(8'h01, 3, 32'h0, 5'b10000);
        st(8'h02, 4, 32'h0, 5'b00000);
        st(8'h10, 5, 32'h1410, 5'b00000);
        st(8'h00, -1, 32'h0, 5'b00000);
        pulse_start();
        repeat (7) @(posedge clk);
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        drain(5, "reset_mid_wait");
        run_ld_finish("restart_entry0");
        reset_expect();

        // REG_WR with csb_ready held low
        mem[0] = mk(8'h30, 0, 32'h10, 32'h20);
        csb_ready = 1'b0;
        st(8'h01, 1, 32'h0, 5'b10000);
        st(8'h02, 2, 32'h0, 5'b00000);
        st(8'h30, 3, 32'h30, 5'b01000);
`ifdef SYN_TB_CSB_TIMEOUT_EN
        push(K_CSB, 8'h00, 1024, 32'h10, 32'h20, 5'b00001);
        st(8'hEE, 1027, 32'h30, 5'b00111);
        push(K_DF, 8'h00, 1, 0, 0, 5'b0);
        pulse_start();
        drain(1200, "csb_timeout");
        reset_expect();
`else
        pulse_start();
        repeat (4999) @(posedge clk);
        #1;
        check("csb_no_timeout", {cs, csb_req} == {8'h30, 1'b1},
              128'({cs, csb_req}), 128'({8'h30, 1'b1}));
        drain(1, "csb_no_timeout_events");
        push(K_CSB, 8'h00, -1, 32'h10, 32'h20, 5'b00001);
        reset_expect();
`endif

        repeat (3) @(posedge clk);
        #1;
        drain(1, "final_queue");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
